// File: rtl/spi_adc_seq.sv
// Frame sequencer for the SPI ADC capture path.
// Drives cs_n, sclk and the shift-register enable window (stp_en), then
// latches the finished word from the external shift register and pulses
// sample_valid for one clock. Supports single-shot and continuous framing.
//
// Handshake: start/cont are level inputs sampled on the rising clk edge while
// the sequencer is IDLE (cont is also sampled on the last HOLD cycle);
// sample_valid is a one-cycle strobe with no back-pressure, and sample stays
// stable until the next strobe.
module spi_adc_seq #(
    parameter int ADC_WIDTH  = 8,
    parameter int FRAME_BITS = 16,
    parameter int LEAD_BITS  = 3,
    parameter int CLK_DIV    = 4,
    parameter int QUIET_CYC  = 2
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 start,
    input  logic                 cont,
    input  logic [ADC_WIDTH-1:0] cur_vd,
    output logic                 sclk,
    output logic                 cs_n,
    output logic                 stp_en,
    output logic                 busy,
    output logic [ADC_WIDTH-1:0] sample,
    output logic                 sample_valid
);

    // One counter serves both the sclk half-period and the quiet gap.
    localparam int CMAX = (CLK_DIV > QUIET_CYC) ? CLK_DIV : QUIET_CYC;
    localparam int DW   = (CMAX > 1) ? $clog2(CMAX) : 1;
    localparam int BW   = $clog2(FRAME_BITS + 1);

    localparam logic [DW-1:0] DIV_LAST   = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] QUIET_LAST = DW'(QUIET_CYC - 1);
    localparam logic [DW-1:0] CNT_ONE    = DW'(1);
    localparam logic [BW-1:0] BIT_LAST   = BW'(FRAME_BITS);
    localparam logic [BW-1:0] BIT_ONE    = BW'(1);
    // bit_cnt value at the rising edge just before a falling edge inside the window
    localparam logic [BW-1:0] WIN_LO     = BW'(LEAD_BITS);
    localparam logic [BW-1:0] WIN_HI     = BW'(LEAD_BITS + ADC_WIDTH - 1);
    // With no leading zeros the very first falling edge carries data
    localparam logic          STP_AT_T   = (LEAD_BITS == 0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        SHIFT = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t                 state, state_nx;
    logic [DW-1:0]          cnt, cnt_nx;
    logic [BW-1:0]          bit_cnt, bit_nx;
    logic                   sclk_nx, stp_nx, valid_nx;
    logic [ADC_WIDTH-1:0]   sample_nx;

    // State and registered outputs; reset forces idle pin levels at once.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state        <= IDLE;
            cnt          <= '0;
            bit_cnt      <= '0;
            sclk         <= 1'b1;
            stp_en       <= 1'b0;
            sample       <= '0;
            sample_valid <= 1'b0;
        end else begin
            state        <= state_nx;
            cnt          <= cnt_nx;
            bit_cnt      <= bit_nx;
            sclk         <= sclk_nx;
            stp_en       <= stp_nx;
            sample       <= sample_nx;
            sample_valid <= valid_nx;
        end
    end

    // Next-state logic: sclk toggles every CLK_DIV cycles in SHIFT, stp_en
    // only moves on rising edges so it is stable across every falling edge.
    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt + CNT_ONE;
        bit_nx    = bit_cnt;
        sclk_nx   = sclk;
        stp_nx    = stp_en;
        valid_nx  = 1'b0;
        sample_nx = sample;
        case (state)
            IDLE: begin
                cnt_nx = '0;
                if (start || cont) begin
                    state_nx = SETUP;
                    bit_nx   = '0;
                    stp_nx   = STP_AT_T;
                end
            end
            SETUP: begin
                if (cnt == DIV_LAST) begin
                    state_nx = SHIFT;
                    cnt_nx   = '0;
                    sclk_nx  = 1'b0;
                    bit_nx   = BIT_ONE;
                end
            end
            SHIFT: begin
                if (cnt == DIV_LAST) begin
                    cnt_nx = '0;
                    if (sclk) begin
                        sclk_nx = 1'b0;
                        bit_nx  = bit_cnt + BIT_ONE;
                    end else begin
                        sclk_nx = 1'b1;
                        if (bit_cnt == BIT_LAST) begin
                            state_nx  = HOLD;
                            stp_nx    = 1'b0;
                            sample_nx = cur_vd;
                            valid_nx  = 1'b1;
                        end else begin
                            stp_nx = (bit_cnt >= WIN_LO) && (bit_cnt <= WIN_HI);
                        end
                    end
                end
            end
            HOLD: begin
                if (cnt == QUIET_LAST) begin
                    cnt_nx = '0;
                    if (cont) begin
                        state_nx = SETUP;
                        bit_nx   = '0;
                        stp_nx   = STP_AT_T;
                    end else begin
                        state_nx = IDLE;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Chip select is released in IDLE and during the quiet gap.
    assign cs_n = (state == IDLE) || (state == HOLD);
    assign busy = (state != IDLE);

endmodule

// File: tb/tb_spi_adc_seq.sv
// Bench for spi_adc_seq: frame-relative waveform model plus ADC/shift-register
// model, per-cycle compare, directed timing checks and a corner instance.
module tb_spi_adc_seq;

  localparam int W  = 8;
  localparam int FB = 16;
  localparam int L  = 3;
  localparam int CD = 4;
  localparam int Q  = 2;
  localparam int FT = 2 * CD * FB;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic n_rst = 1'b0;
  logic start = 1'b0;
  logic cont = 1'b0;
  logic [W-1:0] cur_vd;
  logic sclk, cs_n, stp_en, busy, sample_valid;
  logic [W-1:0] sample;

  logic start2 = 1'b0;
  logic cont2 = 1'b0;
  logic [7:0] cur_vd2;
  logic sclk2, cs_n2, stp_en2, busy2, valid2;
  logic [7:0] sample2;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  spi_adc_seq dut (
    .clk(clk), .n_rst(n_rst), .start(start), .cont(cont), .cur_vd(cur_vd),
    .sclk(sclk), .cs_n(cs_n), .stp_en(stp_en), .busy(busy),
    .sample(sample), .sample_valid(sample_valid)
  );

  spi_adc_seq #(.ADC_WIDTH(8), .FRAME_BITS(8), .LEAD_BITS(0), .CLK_DIV(1), .QUIET_CYC(2)) dut2 (
    .clk(clk), .n_rst(n_rst), .start(start2), .cont(cont2), .cur_vd(cur_vd2),
    .sclk(sclk2), .cs_n(cs_n2), .stp_en(stp_en2), .busy(busy2),
    .sample(sample2), .sample_valid(valid2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- ADC + external shift register ----------------
  logic [W-1:0] adc_word = '0;
  logic [W-1:0] sr = '0;
  int fall_k = 0;
  assign cur_vd = sr;

  always @(negedge sclk) begin
    logic b;
    fall_k++;
    b = (fall_k > L && fall_k <= L + W) ? adc_word[W-1-(fall_k-L-1)] : 1'b0;
    if (stp_en) sr = {sr[W-2:0], b};
  end
  always @(posedge cs_n or negedge n_rst) fall_k = 0;

  logic [7:0] adc_word2 = 8'h3C;
  logic [7:0] sr2 = '0;
  int fall_k2 = 0;
  assign cur_vd2 = sr2;

  always @(negedge sclk2) begin
    logic b;
    fall_k2++;
    b = (fall_k2 >= 1 && fall_k2 <= 8) ? adc_word2[8-fall_k2] : 1'b0;
    if (stp_en2) sr2 = {sr2[6:0], b};
  end
  always @(posedge cs_n2 or negedge n_rst) fall_k2 = 0;

  // ---------------- behavioural model ----------------
  // Frame described by p = clk cycles since SETUP entry.
  bit m_act = 1'b0;
  int p = 0;
  bit m_valid = 1'b0;
  logic [W-1:0] m_sample = '0;
  logic [W-1:0] exp_q[$];
  int word_mode = 0;
  logic [W-1:0] alt = 8'hFF;

  function automatic logic [W-1:0] next_word();
    if (word_mode == 1) begin
      alt = ~alt;
      return alt;
    end else if (word_mode == 2) begin
      return 8'hA5;
    end
    return W'($urandom_range(0, 255));
  endfunction

  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      m_act = 1'b0;
      p = 0;
      m_valid = 1'b0;
      m_sample = '0;
      exp_q.delete();
    end else begin
      m_valid = 1'b0;
      if (!m_act) begin
        if (start || cont) begin
          m_act = 1'b1;
          p = 0;
          adc_word = next_word();
          exp_q.push_back(adc_word);
        end
      end else begin
        p++;
        if (p == FT) m_valid = 1'b1;
        if (p == FT + Q) begin
          if (cont) begin
            p = 0;
            adc_word = next_word();
            exp_q.push_back(adc_word);
          end else begin
            m_act = 1'b0;
          end
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(posedge clk) begin
    logic e_cs, e_sclk, e_stp, e_busy;
    #1;
    if (chk_en) begin
      e_cs = 1'b1; e_sclk = 1'b1; e_stp = 1'b0; e_busy = m_act;
      if (m_act && p < FT) begin
        e_cs = 1'b0;
        e_sclk = ((p / CD) % 2) == 0;
        e_stp = (p >= 2 * CD * L) && (p < 2 * CD * (L + W));
      end
      if (m_valid) begin
        check("exp_q_nonempty", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) m_sample = exp_q.pop_front();
      end
      check("cs_n", cs_n, e_cs);
      check("sclk", sclk, e_sclk);
      check("stp_en", stp_en, e_stp);
      check("busy", busy, e_busy);
      check("sample_valid", sample_valid, m_valid);
      check("sample", sample, m_sample);
    end
  end

  // ---------------- driver tasks ----------------
  int T;
  int first_fall, last_fall, n_falls, stp_rise, stp_fall, n_valid, valid_at, cs_rise, idle_at, bad_runs;
  int vq[$];

  // Pulse start (or rely on cont) and find the SETUP entry edge T.
  task automatic begin_frame(input bit use_start);
    bit found = 1'b0;
    @(negedge clk);
    if (use_start) start = 1'b1;
    for (int i = 0; i < 20 && !found; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (!cs_n) begin
        found = 1'b1;
        T = cyc;
      end
    end
    check("frame_start_seen", found, 1);
  endtask

  // Record event times relative to T for ncyc cycles; optionally pulse start
  // so that it is sampled on edge T+start_at.
  task automatic capture(input int ncyc, input int start_at);
    logic ps, pst, pcs;
    int r, cs_r;
    first_fall = -1; last_fall = -1; n_falls = 0; stp_rise = -1; stp_fall = -1;
    n_valid = 0; valid_at = -1; cs_rise = -1; idle_at = -1; bad_runs = 0; cs_r = -1;
    vq.delete();
    ps = sclk; pst = stp_en; pcs = cs_n;
    for (int i = 0; i < ncyc; i++) begin
      @(posedge clk); #1;
      r = cyc - T;
      start = (r == start_at - 1);
      if (ps && !sclk) begin
        n_falls++;
        if (first_fall < 0) first_fall = r;
        last_fall = r;
      end
      if (!pst && stp_en && stp_rise < 0) stp_rise = r;
      if (pst && !stp_en && stp_fall < 0) stp_fall = r;
      if (sample_valid) begin
        n_valid++;
        if (valid_at < 0) valid_at = r;
        vq.push_back(r);
      end
      if (!pcs && cs_n) begin
        if (cs_rise < 0) cs_rise = r;
        cs_r = r;
      end
      if (pcs && !cs_n && cs_r >= 0 && (r - cs_r) != Q) bad_runs++;
      if (!busy && idle_at < 0) idle_at = r;
      ps = sclk; pst = stp_en; pcs = cs_n;
    end
    start = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    // Reset with inputs active: outputs must sit at idle levels.
    start = 1'b1; cont = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_sclk", sclk, 1);
    check("rst_cs_n", cs_n, 1);
    check("rst_stp_en", stp_en, 0);
    check("rst_busy", busy, 0);
    check("rst_sample", sample, 0);
    check("rst_valid", sample_valid, 0);
    start = 1'b0; cont = 1'b0;
    @(negedge clk);
    n_rst = 1'b1;
    chk_en = 1'b1;
    repeat (3) @(negedge clk);

    // Single shot, word A5.
    word_mode = 2;
    begin_frame(1'b1);
    capture(140, -10);
    check("ss_first_fall", first_fall, 4);
    check("ss_last_fall", last_fall, 124);
    check("ss_n_falls", n_falls, 16);
    check("ss_stp_rise", stp_rise, 24);
    check("ss_stp_fall", stp_fall, 88);
    check("ss_valid_at", valid_at, 128);
    check("ss_n_valid", n_valid, 1);
    check("ss_cs_rise", cs_rise, 128);
    check("ss_idle_at", idle_at, 130);
    check("ss_sample", sample, 8'hA5);

    // Start while busy is ignored.
    word_mode = 0;
    begin_frame(1'b1);
    capture(200, 50);
    check("bz_n_falls", n_falls, 16);
    check("bz_n_valid", n_valid, 1);
    check("bz_idle_at", idle_at, 130);

    // Continuous, alternating 00/FF.
    word_mode = 1;
    @(negedge clk); cont = 1'b1;
    begin_frame(1'b0);
    capture(4 * 130 + 10, -10);
    check("ct_n_valid", n_valid, 4);
    for (int i = 1; i < vq.size(); i++) check("ct_valid_gap", vq[i] - vq[i-1], 130);
    check("ct_bad_quiet", bad_runs, 0);
    check("ct_sample_last", sample, 8'hFF);
    // Drop cont mid-frame: the frame completes and the sequencer idles.
    repeat (60) @(negedge clk);
    cont = 1'b0;
    repeat (140) @(negedge clk);
    check("ct_end_idle", busy, 0);
    check("ct_end_sample", sample, 8'h00);

    // Reset mid-frame.
    word_mode = 2;
    @(negedge clk); n_rst = 1'b0; @(negedge clk); n_rst = 1'b1;
    begin_frame(1'b1);
    repeat (59) @(posedge clk);
    #1; n_rst = 1'b0; #1;
    check("mr_sclk", sclk, 1);
    check("mr_cs_n", cs_n, 1);
    check("mr_stp_en", stp_en, 0);
    check("mr_busy", busy, 0);
    check("mr_sample", sample, 0);
    @(negedge clk); n_rst = 1'b1;
    begin_frame(1'b1);
    capture(140, -10);
    check("mr_n_falls", n_falls, 16);
    check("mr_valid_at", valid_at, 128);
    check("mr_sample_after", sample, 8'hA5);

    // Randomized traffic.
    word_mode = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      start = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 199) == 0) cont = ~cont;
      n_rst = ($urandom_range(0, 1499) != 0);
    end
    @(negedge clk);
    start = 1'b0; cont = 1'b0; n_rst = 1'b1;
    repeat (150) @(negedge clk);
    chk_en = 1'b0;

    // Corner instance: CLK_DIV=1, LEAD_BITS=0, FRAME_BITS=ADC_WIDTH=8.
    begin
      bit found = 1'b0;
      int t2 = 0, s_fall = -1, v_at = -1, n_v = 0;
      logic pst2;
      @(negedge clk); start2 = 1'b1;
      for (int i = 0; i < 10 && !found; i++) begin
        @(posedge clk); #1;
        start2 = 1'b0;
        if (!cs_n2) begin found = 1'b1; t2 = cyc; end
      end
      check("cn_start_seen", found, 1);
      check("cn_stp_at_T", stp_en2, 1);
      pst2 = stp_en2;
      for (int i = 0; i < 25; i++) begin
        @(posedge clk); #1;
        if (pst2 && !stp_en2 && s_fall < 0) s_fall = cyc - t2;
        if (valid2) begin n_v++; if (v_at < 0) v_at = cyc - t2; end
        pst2 = stp_en2;
      end
      check("cn_stp_fall", s_fall, 16);
      check("cn_valid_at", v_at, 16);
      check("cn_n_valid", n_v, 1);
      check("cn_sample", sample2, 8'h3C);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, compared %0d mismatched %0d", n_cmp, n_err);
    $fatal(1);
  end

endmodule
